vga_mem_scheduler: RTL
======================

VGA_MEM_SCHEDULER -- requirements
Module: vga_mem_scheduler

Interface
REQ-001 Parameter ADDR_W, default 14: word address width of one framebuffer.
REQ-002 Parameter DATA_W, default 18: pixel word width, {r[5:0],g[5:0],b[5:0]}.
REQ-003 Port clock, in, 1: single clock for all logic.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port in_vblank, in, 1: vertical blank flag from the VGA driver.
REQ-006 Port in_disp_req, in, 1: display read request, one word per asserted cycle.
REQ-007 Port in_disp_addr, in, ADDR_W: display read address within the front buffer.
REQ-008 Port out_disp_data, out, DATA_W: display read data.
REQ-009 Port out_disp_valid, out, 1: out_disp_data is valid this cycle.
REQ-010 Port in_wr_valid, in, 1: writer has a word.
REQ-011 Port in_wr_addr, in, ADDR_W: writer address within the back buffer.
REQ-012 Port in_wr_data, in, DATA_W: writer data.
REQ-013 Port out_wr_ready, out, 1: writer word is accepted this cycle.
REQ-014 Port in_swap_req, in, 1: single-cycle request to exchange front and back buffers.
REQ-015 Port out_swap_pending, out, 1: a swap is queued and not yet performed.
REQ-016 Port out_front, out, 1: index of the current front buffer.
REQ-017 Port out_frame, out, 8: frame counter.
REQ-018 Port out_mem_en / out_mem_we, out, 1 each: memory enable and write enable (registered).
REQ-019 Port out_mem_addr, out, ADDR_W+1: memory address; the MSB is the buffer select (registered).
REQ-020 Port out_mem_wdata, out, DATA_W: memory write data (registered).
REQ-021 Port in_mem_rdata, in, DATA_W: memory read data, valid one cycle after the addressed cycle.

Function
REQ-022 The FSM SHALL have three states: RUN, PEND and SWAP.
- RUN -> PEND when in_swap_req is 1.
- PEND -> SWAP on the cycle the rising edge of in_vblank is detected.
- SWAP -> RUN after exactly one cycle.
REQ-023 The vblank rising edge SHALL be detected as in_vblank=1 while the registered previous in_vblank=0.
REQ-024 In SWAP, out_front SHALL toggle at the end of that cycle, and out_wr_ready SHALL be 0 during it.
REQ-025 in_swap_req SHALL be ignored in PEND and in SWAP; a swap is never queued twice.
REQ-026 If in_swap_req coincides with a vblank rising edge while in RUN, the swap SHALL wait for the next vblank rising edge.
REQ-027 out_swap_pending SHALL equal (state==PEND).
REQ-028 out_frame SHALL increment on every vblank rising edge and wrap from 255 to 0.
REQ-029 Arbitration: the display has absolute priority.
- out_wr_ready SHALL equal ~in_disp_req & (state!=SWAP), combinationally.
REQ-030 A display grant in cycle t SHALL register out_mem_en=1, out_mem_we=0 and out_mem_addr={out_front, in_disp_addr}.
REQ-031 For that grant, out_disp_valid SHALL be 1 in cycle t+2, with out_disp_data = in_mem_rdata captured in that cycle.
- Fixed 2-cycle latency.
- Back-to-back requests yield back-to-back valids.
REQ-032 A write handshake in cycle t (in_wr_valid & out_wr_ready) SHALL register the following:
- out_mem_en=1 and out_mem_we=1;
- out_mem_addr={~out_front, in_wr_addr};
- out_mem_wdata=in_wr_data.
REQ-033 With neither a grant nor a write, out_mem_en and out_mem_we SHALL be registered 0.
REQ-034 The buffer select used SHALL be the out_front value before any toggle in that cycle.
REQ-035 Writes SHALL never address the front buffer, and display reads SHALL never address the back buffer.

Reset
REQ-036 On reset=0, all outputs SHALL clear immediately:
- state=RUN;
- out_front=0 and out_frame=0;
- out_swap_pending=0;
- out_disp_valid=0 and out_disp_data=0;
- out_mem_en, out_mem_we, out_mem_addr and out_mem_wdata all 0;
- previous-vblank register=0.
REQ-037 Reads in flight at reset SHALL be discarded; no out_disp_valid SHALL appear after reset release for them.
REQ-038 While reset=0, out_wr_ready SHALL be 0.

Structure
REQ-039 A shared package SHALL hold the following:
- the FSM state encoding (RUN=0, PEND=1, SWAP=2);
- the default DATA_W and ADDR_W;
- the pixel field offsets (b=0, g=6, r=12).
REQ-040 The block SHALL contain one sub-module, vga_edge_detect, a registered rising-edge detector with the same clock and reset, used for in_vblank.
REQ-041 The display latency pipeline SHALL be a 2-stage valid shift register inside the top module; no FIFO.

Verification
REQ-042 Display 0x0010 at t=0,1,2 with memory model (addr MSB=0) -> out_disp_valid at t=2,3,4 with the data of addresses 0x0010, 0x0011, 0x0012.
REQ-043 in_wr_valid=1 held while in_disp_req=1 for 5 cycles -> out_wr_ready=0 for those 5 cycles, then 1; exactly one write occurs, with out_mem_addr MSB=1.
REQ-044 in_swap_req pulse at mid-frame -> out_swap_pending=1 until the vblank rising edge; out_front 0->1 one cycle after SWAP; subsequent writes use MSB=0.
REQ-045 in_swap_req asserted twice before a vblank -> exactly one toggle of out_front.
REQ-046 256 vblank rising edges -> out_frame returns to 0.
REQ-047 reset=0 asserted during PEND with a read in flight -> state=RUN, out_front=0, no out_disp_valid after release.

Source files
------------

// File: rtl/vga_mem_scheduler_pkg.sv
// Shared definitions for the VGA framebuffer memory scheduler.
//   - scheduler FSM state encoding
//   - default framebuffer geometry (word address width, pixel width)
//   - bit offsets of the colour fields inside an 18-bit pixel word
package vga_mem_scheduler_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 18;

   // Pixel word layout: {r[5:0], g[5:0], b[5:0]}
   localparam int PIX_B_OFS = 0;
   localparam int PIX_G_OFS = 6;
   localparam int PIX_R_OFS = 12;
   localparam int PIX_CH_W  = 6;

   // Display read latency: grant cycle -> data cycle
   localparam int DISP_LAT = 2;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PEND = 2'd1,
      ST_SWAP = 2'd2
   } sched_state_e;

endpackage

// File: rtl/vga_mem_scheduler_edge_detect.sv
// Registered rising-edge detector.
// Ports:
//   clock    - clock
//   reset    - asynchronous active-low reset (clears the history register)
//   in_sig   - level input
//   out_rise - 1 while in_sig is 1 and its value in the previous cycle was 0
module vga_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic in_sig,
   output logic out_rise
);

   logic prev_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prev_q <= 1'b0;
      else        prev_q <= in_sig;
   end

   assign out_rise = in_sig & ~prev_q;

endmodule

// File: rtl/vga_mem_scheduler.sv
// Double-buffered framebuffer memory scheduler.
// One single-port memory holds two framebuffers; the address MSB selects the
// buffer. The display reads the front buffer with absolute priority; the
// writer fills the back buffer in the remaining cycles. A swap request is
// queued and performed on the next vertical-blank rising edge.
// Ports:
//   clock, reset                     - clock, async active-low reset
//   in_vblank                        - vertical blank level from the VGA driver
//   in_disp_req / in_disp_addr       - display read request (one word per cycle)
//   out_disp_data / out_disp_valid   - display read data, 2 cycles after grant
//   in_wr_valid/_addr/_data          - writer word
//   out_wr_ready                     - writer word accepted this cycle
//   in_swap_req                      - pulse: exchange front/back at next vblank
//   out_swap_pending                 - swap queued, not yet performed
//   out_front                        - current front buffer index
//   out_frame                        - vblank counter (wraps at 256)
//   out_mem_en/we/addr/wdata         - registered memory command
//   in_mem_rdata                     - memory read data, 1 cycle after command
module vga_mem_scheduler
   import vga_mem_scheduler_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_vblank,
   input  logic              in_disp_req,
   input  logic [ADDR_W-1:0] in_disp_addr,
   output logic [DATA_W-1:0] out_disp_data,
   output logic              out_disp_valid,
   input  logic              in_wr_valid,
   input  logic [ADDR_W-1:0] in_wr_addr,
   input  logic [DATA_W-1:0] in_wr_data,
   output logic              out_wr_ready,
   input  logic              in_swap_req,
   output logic              out_swap_pending,
   output logic              out_front,
   output logic [7:0]        out_frame,
   output logic              out_mem_en,
   output logic              out_mem_we,
   output logic [ADDR_W:0]   out_mem_addr,
   output logic [DATA_W-1:0] out_mem_wdata,
   input  logic [DATA_W-1:0] in_mem_rdata
);

   sched_state_e state_q, state_d;
   logic         vblank_rise;
   logic         disp_grant;
   logic         wr_fire;
   logic [DISP_LAT:1] vld_pipe;

   vga_edge_detect u_vblank_edge (
      .clock    (clock),
      .reset    (reset),
      .in_sig   (in_vblank),
      .out_rise (vblank_rise)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // A request arriving together with a vblank edge lands in PEND after that
   // edge has passed, so it naturally waits for the following one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (in_swap_req) state_d = ST_PEND;
         ST_PEND: if (vblank_rise) state_d = ST_SWAP;
         ST_SWAP: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   assign out_swap_pending = (state_q == ST_PEND);

   // Front index flips at the end of the SWAP cycle; the SWAP cycle itself
   // blocks writes so no write can straddle the toggle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                  out_front <= 1'b0;
      else if (state_q == ST_SWAP) out_front <= ~out_front;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           out_frame <= 8'd0;
      else if (vblank_rise) out_frame <= out_frame + 8'd1;
   end

   // --------------------------------------------------------- arbitration
   assign disp_grant   = in_disp_req;
   assign out_wr_ready = reset & ~in_disp_req & (state_q != ST_SWAP);
   assign wr_fire      = in_wr_valid & out_wr_ready;

   // Address/data hold their last value on idle cycles; only en/we clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_mem_en    <= 1'b0;
         out_mem_we    <= 1'b0;
         out_mem_addr  <= '0;
         out_mem_wdata <= '0;
      end else begin
         out_mem_en <= disp_grant | wr_fire;
         out_mem_we <= wr_fire;
         if (disp_grant) begin
            out_mem_addr <= {out_front, in_disp_addr};
         end else if (wr_fire) begin
            out_mem_addr  <= {~out_front, in_wr_addr};
            out_mem_wdata <= in_wr_data;
         end
      end
   end

   // ---------------------------------------------------- display latency
   // Stage 1: command on the memory port; stage 2: read data on in_mem_rdata.
   // Clearing on reset drops any read in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[DISP_LAT-1:1], disp_grant};
   end

   assign out_disp_valid = vld_pipe[DISP_LAT];
   assign out_disp_data  = out_disp_valid ? in_mem_rdata : '0;

endmodule
